// File: rtl/load_store_unit_if.sv
// load_store_unit_if: request/response handshake between the MEM stage and the load/store unit.
interface load_store_unit_if #(parameter int ADDR_W = 16);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_byte;
    logic              req_hi;
    logic              req_signed;
    logic [ADDR_W-1:0] req_addr;
    logic [15:0]       req_wdata;
    logic              resp_valid;
    logic [15:0]       resp_rdata;
    logic              resp_err;
    modport master (
        output req_valid, req_write, req_byte, req_hi, req_signed, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_write, req_byte, req_hi, req_signed, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/load_store_unit.sv
// load_store_unit: data-memory initiator with word/byte loads, read-modify-write byte stores and range checking.
module load_store_unit #(
    parameter int ADDR_W    = 16,
    parameter int MEM_WORDS = 8192,
    parameter int RD_LAT    = 1
) (
    input  logic                clk,
    input  logic                rst,
    load_store_unit_if.slave    bus,
    output logic                busy,
    output logic [15:0]         A_DataAddress,
    output logic [15:0]         D_WriteData,
    output logic                C_DMRead,
    output logic                C_DMWrite,
    input  logic [15:0]         D_Data
);
    localparam int CW = $clog2(RD_LAT + 2);
    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, RESP} state_t;
    state_t            state;
    logic              idle_q;
    logic              write_q;
    logic              byte_q;
    logic              hi_q;
    logic              signed_q;
    logic [ADDR_W-1:0] addr_q;
    logic [7:0]        wbyte_q;
    logic [CW-1:0]     cnt;
    logic [7:0]        lane;
    assign lane = hi_q ? D_Data[15:8] : D_Data[7:0];
    // Gated by rst so the requester never sees ready while reset is held.
    assign bus.req_ready = idle_q & ~rst;
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            idle_q         <= 1'b1;
            busy           <= 1'b0;
            bus.resp_valid <= 1'b0;
            bus.resp_err   <= 1'b0;
            bus.resp_rdata <= '0;
            A_DataAddress  <= '0;
            D_WriteData    <= '0;
            C_DMRead       <= 1'b0;
            C_DMWrite      <= 1'b0;
            cnt            <= '0;
        end else begin
            case (state)
                IDLE: if (bus.req_valid) begin
                    addr_q   <= bus.req_addr;
                    write_q  <= bus.req_write;
                    byte_q   <= bus.req_byte;
                    hi_q     <= bus.req_hi;
                    signed_q <= bus.req_signed;
                    wbyte_q  <= bus.req_wdata[7:0];
                    idle_q   <= 1'b0;
                    busy     <= 1'b1;
                    if (32'(bus.req_addr) >= MEM_WORDS) begin
                        state          <= RESP;
                        bus.resp_valid <= 1'b1;
                        bus.resp_err   <= 1'b1;
                        bus.resp_rdata <= '0;
                    end else if (bus.req_write && !bus.req_byte) begin
                        state         <= WRITE;
                        C_DMWrite     <= 1'b1;
                        A_DataAddress <= 16'(bus.req_addr);
                        D_WriteData   <= bus.req_wdata;
                    end else begin
                        state         <= READ;
                        C_DMRead      <= 1'b1;
                        A_DataAddress <= 16'(bus.req_addr);
                    end
                end
                READ: begin
                    C_DMRead <= 1'b0;
                    cnt      <= CW'(1);
                    state    <= WAIT;
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(RD_LAT)) begin
                        if (write_q) begin
                            state       <= WRITE;
                            C_DMWrite   <= 1'b1;
                            D_WriteData <= hi_q ? {wbyte_q, D_Data[7:0]} : {D_Data[15:8], wbyte_q};
                        end else begin
                            state          <= RESP;
                            bus.resp_valid <= 1'b1;
                            bus.resp_err   <= 1'b0;
                            bus.resp_rdata <= !byte_q ? D_Data : {signed_q ? {8{lane[7]}} : 8'h00, lane};
                        end
                    end
                end
                WRITE: begin
                    C_DMWrite      <= 1'b0;
                    state          <= RESP;
                    bus.resp_valid <= 1'b1;
                    bus.resp_err   <= 1'b0;
                    bus.resp_rdata <= '0;
                end
                RESP: begin
                    bus.resp_valid <= 1'b0;
                    state          <= IDLE;
                    idle_q         <= 1'b1;
                    busy           <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    idle_q <= 1'b1;
                    busy   <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors against a behavioural registered data memory.
module tb_load_store_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        busy;
    logic [15:0] A_DataAddress;
    logic [15:0] D_WriteData;
    logic        C_DMRead;
    logic        C_DMWrite;
    logic [15:0] D_Data = '0;
    logic [15:0] mem [0:8191];
    logic        pl_en = 1'b0;
    logic [12:0] pl_addr = '0;
    logic [15:0] pl_data = '0;
    int          checks = 0;
    int          failures = 0;
    int          rv_cnt;
    load_store_unit_if #(.ADDR_W(16)) bus ();
    load_store_unit #(.ADDR_W(16), .MEM_WORDS(8192), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy),
        .A_DataAddress(A_DataAddress), .D_WriteData(D_WriteData),
        .C_DMRead(C_DMRead), .C_DMWrite(C_DMWrite), .D_Data(D_Data)
    );
    always #5 clk = ~clk;
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        if (C_DMRead) D_Data <= mem[A_DataAddress[12:0]];
        if (C_DMWrite) mem[A_DataAddress[12:0]] <= D_WriteData;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic preload(input logic [12:0] a, input logic [15:0] d);
        @(negedge clk);
        pl_en = 1'b1;
        pl_addr = a;
        pl_data = d;
        @(negedge clk);
        pl_en = 1'b0;
    endtask
    task automatic txn(input string tag, input logic w, b, h, s, input logic [15:0] addr, wd,
                       input logic keep, input int exp_wait, exp_lat, exp_nrd, exp_nwr,
                       input logic [15:0] exp_a, exp_rd, exp_wd, input logic exp_err);
        int waited = 0;
        int lat = 99;
        int nrd = 0;
        int nwr = 0;
        logic stay_ok = 1'b1;
        logic [15:0] a_seen = '0;
        logic [15:0] wd_seen = '0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_byte = b;
        bus.req_hi = h;
        bus.req_signed = s;
        bus.req_addr = addr;
        bus.req_wdata = wd;
        while (!bus.req_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        check({tag, "_accept"}, 32'(bus.req_ready), 32'd1);
        if (exp_wait >= 0) check({tag, "_wait"}, waited, exp_wait);
        @(posedge clk);
        #1;
        if (!keep) bus.req_valid = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (bus.req_ready || !busy || (C_DMRead && C_DMWrite)) stay_ok = 1'b0;
            if (C_DMRead) begin
                nrd++;
                a_seen = A_DataAddress;
            end
            if (C_DMWrite) begin
                nwr++;
                a_seen = A_DataAddress;
                wd_seen = D_WriteData;
            end
            if (bus.resp_valid) begin
                lat = i;
                break;
            end
        end
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_nrd"}, nrd, exp_nrd);
        check({tag, "_nwr"}, nwr, exp_nwr);
        check({tag, "_busy"}, 32'(stay_ok), 32'd1);
        if (exp_nrd + exp_nwr > 0) check({tag, "_addr"}, a_seen, exp_a);
        if (exp_nwr > 0) check({tag, "_wdata"}, wd_seen, exp_wd);
        check({tag, "_rdata"}, bus.resp_rdata, exp_rd);
        check({tag, "_err"}, 32'(bus.resp_err), 32'(exp_err));
    endtask
    initial begin
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_byte = 1'b0;
        bus.req_hi = 1'b0;
        bus.req_signed = 1'b0;
        bus.req_addr = '0;
        bus.req_wdata = '0;
        repeat (3) @(negedge clk);
        check("rst_ctl", {bus.resp_valid, bus.resp_err, C_DMRead, C_DMWrite, busy, bus.req_ready}, 32'd0);
        check("rst_a", A_DataAddress, 32'd0);
        check("rst_wd", D_WriteData, 32'd0);
        check("rst_rd", bus.resp_rdata, 32'd0);
        rst = 1'b0;
        preload(13'h0010, 16'hBEEF);
        preload(13'h0004, 16'h80FF);
        preload(13'h0005, 16'hABCD);
        preload(13'h0006, 16'h1234);
        //   tag          w     b     h     s     addr      wdata     keep  wt  lat rd wr  a         rdata     wdata     err
        txn("ld_word",    1'b0, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 0,  3,  1, 0, 16'h0010, 16'hBEEF, 16'h0000, 1'b0);
        txn("ldb_hi_s",   1'b0, 1'b1, 1'b1, 1'b1, 16'h0004, 16'h0000, 1'b0, 0,  3,  1, 0, 16'h0004, 16'hFF80, 16'h0000, 1'b0);
        txn("ldb_lo_u",   1'b0, 1'b1, 1'b0, 1'b0, 16'h0004, 16'h0000, 1'b0, 0,  3,  1, 0, 16'h0004, 16'h00FF, 16'h0000, 1'b0);
        txn("ldb_lo_s",   1'b0, 1'b1, 1'b0, 1'b1, 16'h0004, 16'h0000, 1'b0, 0,  3,  1, 0, 16'h0004, 16'hFFFF, 16'h0000, 1'b0);
        txn("ldb_hi_u",   1'b0, 1'b1, 1'b1, 1'b0, 16'h0004, 16'h0000, 1'b0, 0,  3,  1, 0, 16'h0004, 16'h0080, 16'h0000, 1'b0);
        txn("stb_lo",     1'b1, 1'b1, 1'b0, 1'b0, 16'h0005, 16'h0012, 1'b0, 0,  4,  1, 1, 16'h0005, 16'h0000, 16'hAB12, 1'b0);
        txn("ld_after_lo",1'b0, 1'b0, 1'b0, 1'b0, 16'h0005, 16'h0000, 1'b0, 0,  3,  1, 0, 16'h0005, 16'hAB12, 16'h0000, 1'b0);
        txn("stb_hi",     1'b1, 1'b1, 1'b1, 1'b0, 16'h0006, 16'h55AB, 1'b0, 0,  4,  1, 1, 16'h0006, 16'h0000, 16'hAB34, 1'b0);
        txn("ld_after_hi",1'b0, 1'b0, 1'b0, 1'b0, 16'h0006, 16'h0000, 1'b0, 0,  3,  1, 0, 16'h0006, 16'hAB34, 16'h0000, 1'b0);
        txn("st_word",    1'b1, 1'b0, 1'b0, 1'b0, 16'h1FFF, 16'h1234, 1'b0, 0,  2,  0, 1, 16'h1FFF, 16'h0000, 16'h1234, 1'b0);
        txn("ld_1fff",    1'b0, 1'b0, 1'b0, 1'b0, 16'h1FFF, 16'h0000, 1'b0, 0,  3,  1, 0, 16'h1FFF, 16'h1234, 16'h0000, 1'b0);
        txn("err_2000",   1'b0, 1'b0, 1'b0, 1'b0, 16'h2000, 16'h0000, 1'b0, 0,  1,  0, 0, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        txn("err_st_ffff",1'b1, 1'b0, 1'b0, 1'b0, 16'hFFFF, 16'h9999, 1'b0, 0,  1,  0, 0, 16'h0000, 16'h0000, 16'h0000, 1'b1);
        txn("ld_post_err",1'b0, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b0, 0,  3,  1, 0, 16'h0010, 16'hBEEF, 16'h0000, 1'b0);
        // Reset asserted in the WAIT cycle of a load abandons it.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_byte = 1'b0;
        bus.req_addr = 16'h0010;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(negedge clk);
        check("mid_read", 32'(C_DMRead), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("mid_ctl", {bus.resp_valid, bus.resp_err, C_DMRead, C_DMWrite, busy, bus.req_ready}, 32'd0);
        check("mid_a", A_DataAddress, 32'd0);
        check("mid_rd", bus.resp_rdata, 32'd0);
        rst = 1'b0;
        #1;
        check("mid_ready", 32'(bus.req_ready), 32'd1);
        rv_cnt = 0;
        repeat (5) begin
            @(negedge clk);
            if (bus.resp_valid || C_DMRead || C_DMWrite) rv_cnt++;
        end
        check("mid_quiet", rv_cnt, 0);
        // Back-to-back queued loads with req_valid held high.
        txn("q1",         1'b0, 1'b0, 1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1, 0,  3,  1, 0, 16'h0010, 16'hBEEF, 16'h0000, 1'b0);
        txn("q2",         1'b0, 1'b0, 1'b0, 1'b0, 16'h0005, 16'h0000, 1'b0, 0,  3,  1, 0, 16'h0005, 16'hAB12, 16'h0000, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
